// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported RAM between instruction fetch and the
// data stage. One transaction at a time, fixed RAM_LAT busy cycles, hit
// pulses issued combinationally in the final busy cycle.
module mem_arbiter #(
  parameter int RAM_LAT = 2,
  parameter bit DPRIO   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  // fetch side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  // data side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  localparam int CW = $clog2(RAM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, store_q;
  logic          wr_q, last_d;

  logic d_req, grant_d, grant_i, i_keep, d_keep, last_cyc;

  // Arbitration: only evaluated in IDLE; the completion cycle returns to
  // IDLE first, so a waiting requester is granted one cycle later.
  always_comb begin
    d_req    = dREN | dWEN;
    grant_d  = (state == IDLE) & d_req & (~iREN | DPRIO | ~last_d);
    grant_i  = (state == IDLE) & iREN & ~grant_d;
    // A read survives only while the requester still wants the same address;
    // writes are committed once granted.
    i_keep   = iREN & (iaddr == addr_q);
    d_keep   = wr_q | (dREN & (daddr == addr_q));
    last_cyc = (cnt == '0);
  end

  // Next state and all outputs; outputs are zero unless a transaction is busy.
  always_comb begin
    state_n  = state;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        if (grant_d)      state_n = DBUSY;
        else if (grant_i) state_n = IBUSY;
      end
      IBUSY: begin
        ramREN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (!i_keep) begin
          state_n = IDLE;
        end else if (last_cyc) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_n = IDLE;
        end
      end
      DBUSY: begin
        ramREN   = ~wr_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (!d_keep) begin
          state_n = IDLE;
        end else if (last_cyc) begin
          // A write completes regardless; the hit is only reported if the
          // data stage is still asking for it.
          dhit    = wr_q ? dWEN : 1'b1;
          dload   = wr_q ? '0 : ramload;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, grant-time capture of the request, busy counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      last_d  <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_d | grant_i) begin
        addr_q  <= grant_d ? daddr : iaddr;
        store_q <= dstore;
        wr_q    <= dWEN;
        cnt     <= CNT_INIT;
        last_d  <= grant_d;
      end else if (state != IDLE && !last_cyc) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
